// File: rtl/apb_pkg.sv
//------------------------------------------------------------------------------
// Module      : apb_pkg
// Description : Shared types and default widths for the APB master bridge.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_mst_state_t;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
  } apb_rsp_t;

endpackage

`default_nettype wire

// File: rtl/apb_master_timer.sv
//------------------------------------------------------------------------------
// Module      : apb_master_timer
// Description : ACCESS-phase wait counter; expired_o flags the final allowed
//               wait cycle. Only instantiated with APB_MASTER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module apb_master_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] cnt_q;

  // Saturates at the terminal value so expired_o cannot wrap back low.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      cnt_q <= '0;
    end else if (enable_i && !expired_o) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expired_o = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

`default_nettype wire

// File: rtl/apb_master_bridge.sv
//------------------------------------------------------------------------------
// Module      : apb_master_bridge
// Description : valid/ready command port to APB SETUP/ACCESS requester, one
//               transfer in flight. Optional macro APB_MASTER_TIMEOUT_EN adds
//               an ACCESS wait timeout reported through rsp_err.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  apb_mst_state_t    state_q;
  logic [ADDR_W-1:0] paddr_q;
  logic              psel_q;
  logic              penable_q;
  logic              pwrite_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;
  logic              timeout_d;

`ifdef APB_MASTER_TIMEOUT_EN
  logic timer_expired;

  apb_master_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i    (pclk),
    .rst_ni   (prst),
    .clear_i  (state_q == SETUP),
    .enable_i ((state_q == ACCESS) && !pready),
    .expired_o(timer_expired)
  );

  assign timeout_d = (state_q == ACCESS) && !pready && timer_expired;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout_d          = 1'b0;
`endif

  always_ff @(posedge pclk) begin
    if (!prst) begin
      state_q     <= IDLE;
      paddr_q     <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            paddr_q  <= cmd_addr;
            pwrite_q <= cmd_write;
            pwdata_q <= cmd_write ? cmd_wdata : '0;
            psel_q   <= 1'b1;
            state_q  <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          // pready has priority over a coincident timeout.
          if (pready || timeout_d) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= (pready && !pwrite_q) ? prdata : '0;
            rsp_err_q   <= !pready;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready = prst && (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign paddr     = paddr_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
//------------------------------------------------------------------------------
// Module      : tb_apb_master_bridge
// Description : Scoreboard bench for apb_master_bridge with a word-indexed APB
//               slave model (mem[i]=i at reset). Build with APB_MASTER_TIMEOUT_EN
//               to include the timeout scenario.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_apb_master_bridge;
  import apb_pkg::*;

  logic        clk = 1'b0;
  logic        prst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] paddr, pwdata, prdata;
  logic        psel, penable, pwrite, pready;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    apb_rsp_t rsp;
    int       acc;
    int       lat;
  } exp_t;

  exp_t exp_q[$];

  logic [31:0] exp_addr = '0, exp_pwdata = '0;
  logic        exp_wr = 1'b0;
  int          exp_access = 0;

  logic [31:0] mem [256];
  int          wcnt = 0;
  int          ws   = 0;

  apb_master_bridge #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .pclk(clk), .prst(prst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pready(pready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // APB slave: ws wait states per ACCESS, word-indexed memory.
  assign pready = (wcnt >= ws);
  assign prdata = mem[paddr[7:0]];

  always @(posedge clk) begin
    if (!prst) begin
      for (int i = 0; i < 256; i++) mem[i] <= i;
      wcnt <= 0;
    end else begin
      if (psel && penable && !pready) wcnt <= wcnt + 1;
      else                            wcnt <= 0;
      if (psel && penable && pready && pwrite) mem[paddr[7:0]] <= pwdata;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Response monitor: pops on each new response, then checks it stays stable.
  initial begin
    exp_t cur;
    bit   prev_v;
    prev_v = 1'b0;
    cur    = '{rsp: '0, acc: 0, lat: 0};
    forever begin
      @(negedge clk);
      if (prst && rsp_valid) begin
        if (!prev_v) begin
          if (exp_q.size() == 0) begin
            chk("rsp_unexpected", 64'd1, 64'd0);
          end else begin
            cur = exp_q.pop_front();
            chk("rsp_latency", 64'(cyc - cur.acc), 64'(cur.lat));
          end
        end
        chk("rsp_rdata", 64'(rsp_rdata), 64'(cur.rsp.rdata));
        chk("rsp_err", 64'(rsp_err), 64'(cur.rsp.err));
        chk("rsp_psel_low", 64'({psel, penable}), 64'd0);
        chk("rsp_cmd_ready_low", 64'(cmd_ready), 64'd0);
      end
      prev_v = prst && rsp_valid;
    end
  end

  // APB monitor: address/data stability and ACCESS phase length.
  initial begin
    int acc_run;
    acc_run = 0;
    forever begin
      @(negedge clk);
      if (!prst) begin
        acc_run = 0;
      end else if (psel) begin
        chk("apb_paddr", 64'(paddr), 64'(exp_addr));
        chk("apb_pwrite", 64'(pwrite), 64'(exp_wr));
        chk("apb_pwdata", 64'(pwdata), 64'(exp_pwdata));
        if (penable) acc_run++;
      end else if (acc_run != 0) begin
        chk("apb_access_cycles", 64'(acc_run), 64'(exp_access));
        acc_run = 0;
      end
    end
  end

  // Issue one command starting at a negedge; returns the accept cycle.
  task automatic do_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int wst, input logic [31:0] exp_rd, input bit exp_err,
                        input int n_access, input bit push, output int acc);
    bit ok;
    ok         = 1'b0;
    acc        = 0;
    ws         = wst;
    exp_addr   = addr;
    exp_wr     = wr;
    exp_pwdata = wr ? wdata : 32'd0;
    exp_access = n_access;
    cmd_write  = wr;
    cmd_addr   = addr;
    cmd_wdata  = wdata;
    cmd_valid  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (cmd_ready) begin
        ok  = 1'b1;
        acc = cyc;
        if (push) exp_q.push_back('{rsp: '{rdata: exp_rd, err: exp_err}, acc: cyc, lat: 2 + n_access});
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("cmd_accept_timeout", 64'd0, 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (cmd_ready && !rsp_valid && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("idle_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int acc, acc2, rel;
    bit seen;
    prst = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_psel", 64'(psel), 64'd0);
    chk("rst_penable", 64'(penable), 64'd0);
    chk("rst_pwrite", 64'(pwrite), 64'd0);
    chk("rst_paddr", 64'(paddr), 64'd0);
    chk("rst_pwdata", 64'(pwdata), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    prst = 1'b1;
    @(negedge clk);
    chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);

    // Write, zero wait states.
    do_cmd(1'b1, 32'h10, 32'hDEADBEEF, 0, 32'h0, 1'b0, 1, 1'b1, acc);
    wait_idle();
    // Reads against reset contents and after a write.
    do_cmd(1'b0, 32'h05, 32'h0, 0, 32'h5, 1'b0, 1, 1'b1, acc);
    wait_idle();
    do_cmd(1'b1, 32'h20, 32'hCAFE0001, 0, 32'h0, 1'b0, 1, 1'b1, acc);
    wait_idle();
    do_cmd(1'b0, 32'h20, 32'h0, 0, 32'hCAFE0001, 1'b0, 1, 1'b1, acc);
    wait_idle();
    do_cmd(1'b0, 32'h10, 32'h0, 0, 32'hDEADBEEF, 1'b0, 1, 1'b1, acc);
    wait_idle();

    // Three wait states on a write.
    do_cmd(1'b1, 32'h33, 32'h12345678, 3, 32'h0, 1'b0, 4, 1'b1, acc);
    wait_idle();
    do_cmd(1'b0, 32'h33, 32'h0, 2, 32'h12345678, 1'b0, 3, 1'b1, acc);
    wait_idle();

    // Backpressure: second command must wait for the response handshake.
    rsp_ready = 1'b0;
    do_cmd(1'b0, 32'h07, 32'h0, 0, 32'h7, 1'b0, 1, 1'b1, acc);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("bp_rsp_seen", 64'(seen), 64'd1);
    rel = 0;
    fork
      begin
        repeat (5) @(negedge clk);
        rsp_ready = 1'b1;
        rel = cyc;
      end
      do_cmd(1'b0, 32'h08, 32'h0, 0, 32'h8, 1'b0, 1, 1'b1, acc2);
    join
    chk("bp_second_accept_cycle", 64'(acc2), 64'(rel + 1));
    wait_idle();

    // Reset during ACCESS drops the transfer with no response.
    do_cmd(1'b0, 32'h09, 32'h0, 5, 32'h0, 1'b0, 6, 1'b0, acc);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (psel && penable) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("mr_access_seen", 64'(seen), 64'd1);
    prst = 1'b0;
    @(negedge clk);
    chk("mr_psel", 64'(psel), 64'd0);
    chk("mr_penable", 64'(penable), 64'd0);
    chk("mr_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mr_cmd_ready", 64'(cmd_ready), 64'd0);
    prst = 1'b1;
    @(negedge clk);
    chk("mr_cmd_ready_after", 64'(cmd_ready), 64'd1);
    do_cmd(1'b0, 32'h0A, 32'h0, 1, 32'hA, 1'b0, 2, 1'b1, acc);
    wait_idle();

`ifdef APB_MASTER_TIMEOUT_EN
    // pready stuck low: 16 ACCESS cycles then an error response.
    do_cmd(1'b0, 32'h0B, 32'h0, 1000, 32'h0, 1'b1, 16, 1'b1, acc);
    wait_idle();
    // Completion on the last allowed cycle is a normal response.
    do_cmd(1'b0, 32'h0C, 32'h0, 15, 32'hC, 1'b0, 16, 1'b1, acc);
    wait_idle();
`endif

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Requester end of the APB link: converts a simple valid/ready command port into APB SETUP/ACCESS transfers.
- Drives paddr/psel/penable/pwrite/pwdata, waits on pready, captures prdata and returns a response over a valid/ready port.
- Sits between the on-chip command source (or testbench sequencer) and the dut_if APB slave side.
- One outstanding transfer at a time; no pipelining across transfers.

Parameters:
- ADDR_W, 32, width of cmd_addr and paddr.
- DATA_W, 32, width of write and read data.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles without pready (used only with APB_MASTER_TIMEOUT_EN).

Ports:
- pclk  in  1  APB clock; all logic on posedge.
- prst  in  1  reset; synchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  bridge accepts a command this cycle.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  transfer address.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumer ready.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_err  out  1  transfer aborted by timeout; tied 0 without the optional feature.
- paddr  out  ADDR_W  APB address.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- pwdata  out  DATA_W  APB write data.
- prdata  in  DATA_W  APB read data.
- pready  in  1  APB ready / wait-state control.

Behaviour:
- Clock and reset: one clock pclk; reset prst is synchronous, active-low.
- Reset values: all outputs 0, state IDLE. cmd_ready is forced 0 while prst=0.
- States:
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, register addr/write/wdata and go to SETUP.
  - SETUP: psel=1, penable=0. Unconditionally go to ACCESS next cycle.
  - ACCESS: psel=1, penable=1. On a posedge sampling pready=1, capture prdata into rsp_rdata (reads only; writes give 0), set rsp_err=0, and go to RESP. pready=0 holds ACCESS.
  - RESP: psel=0, penable=0, rsp_valid=1. On rsp_valid&&rsp_ready, go to IDLE with rsp_valid=0.
- Signal stability:
  - paddr, pwrite and pwdata are stable from SETUP through the final ACCESS cycle.
  - pwdata=0 for reads.
  - paddr, pwrite and pwdata hold their last value in IDLE and RESP.
- Latency: command accept to rsp_valid is 3 cycles with zero wait states, plus 1 cycle per pready=0 cycle in ACCESS.
- Throughput: minimum 4 cycles per transfer with rsp_ready tied 1.
- Boundary and corner cases:
  - cmd_valid in any state other than IDLE is ignored and not accepted.
  - rsp_ready low stalls in RESP indefinitely; rsp_rdata and rsp_err stay stable while stalled.
  - Reset asserted in any state: the next posedge forces IDLE and zeroes outputs. psel drops immediately and the in-flight transfer is lost with no response.
  - pready is ignored outside ACCESS.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- With the macro: a counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0. When it reaches TIMEOUT_CYCLES-1 with pready still 0:
  - go to RESP with rsp_err=1 and rsp_rdata=0;
  - psel and penable drop that same edge.
  - pready=1 on the same edge wins: normal completion, rsp_err=0.
- Without the macro: no counter is built, rsp_err is tied 0, and ACCESS waits forever.

Decomposition:
- Shared package apb_pkg:
  - state enum apb_mst_state_t {IDLE, SETUP, ACCESS, RESP};
  - default ADDR_W/DATA_W constants;
  - apb_rsp_t struct {rdata, err}.
- Sub-module apb_master_timer: the timeout counter with clear/enable/expired, instantiated only under APB_MASTER_TIMEOUT_EN.
- Everything else stays in the single FSM module.

Test Plan:
- Write: cmd write addr 0x10, data 0xDEADBEEF, pready=1 -> SETUP then ACCESS with paddr=0x10 and pwdata=0xDEADBEEF; rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0.
- Read-back: against the team APB slave (reset-initialised mem[i]=i), read 0x05 -> rsp_rdata=0x5; write 0x20=0xCAFE0001 then read 0x20 -> 0xCAFE0001.
- Wait states: pready held 0 for 3 ACCESS cycles -> psel/penable stay high 4 ACCESS cycles; paddr and pwdata unchanged; rsp_valid 6 cycles after accept.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, cmd_ready=0, second cmd_valid not accepted until rsp_ready=1.
- Mid-transfer reset: prst=0 during ACCESS -> next edge psel=0, penable=0, rsp_valid=0, cmd_ready=0; after release, cmd_ready=1 and a new read completes normally.
- Timeout (macro on, TIMEOUT_CYCLES=16): pready stuck 0 -> after 16 ACCESS cycles rsp_valid=1, rsp_err=1, rsp_rdata=0, psel=0.
